counter: RTL and testbench

COUNTER -- requirements
Module: counter

---
 rtl/counter.sv | 116 +++++++++++
 tb/tb_counter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/counter.sv
// counter: WIDTH-bit up/down counter with synchronous clear and load and a
// registered wrap indication (one-cycle pulse or sticky, per STICKY_OVERFLOW).
// Priority at each rising edge is clear_i > load_i > en_i.
// Optional simulation checks are compiled in when COUNTER_ASSERT_EN is defined.
module counter #(
  parameter int unsigned WIDTH           = 4,
  parameter bit          STICKY_OVERFLOW = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             down_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             overflow_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;

  logic [WIDTH-1:0] w_q_next;
  logic             w_ovf_next;
  logic             w_step;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_wrap;

  // A step only happens when neither clear nor load claims the edge.
  assign w_step    = en_i & ~clear_i & ~load_i;
  assign w_at_max  = (r_q == {WIDTH{1'b1}});
  assign w_at_zero = (r_q == '0);
  // Wrap: counting up out of all-ones or down out of zero.
  assign w_wrap    = w_step & (down_i ? w_at_zero : w_at_max);

  // Next-state selection for count and overflow flag.
  always_comb begin
    w_q_next   = r_q;
    w_ovf_next = 1'b0;
    if (clear_i) begin
      w_q_next   = '0;
      w_ovf_next = 1'b0;
    end else if (load_i) begin
      w_q_next   = d_i;
      w_ovf_next = 1'b0;
    end else begin
      if (en_i) begin
        w_q_next = down_i ? (r_q - ONE) : (r_q + ONE);
      end
      // Sticky mode keeps the flag until clear/load; pulse mode mirrors
      // only this edge's wrap.
      if (STICKY_OVERFLOW) begin
        w_ovf_next = r_ovf | w_wrap;
      end else begin
        w_ovf_next = w_wrap;
      end
    end
  end

  // State registers; both outputs come straight from these flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_q   <= w_q_next;
      r_ovf <= w_ovf_next;
    end
  end

  assign q_o        = r_q;
  assign overflow_o = r_ovf;

`ifdef COUNTER_ASSERT_EN
  // Elaboration-time guard on the width range.
  if (WIDTH < 1 || WIDTH > 32) begin : g_width_fatal
    $fatal(1, "counter: WIDTH=%0d outside 1..32", WIDTH);
  end

  logic             s_prev_idle;
  logic [WIDTH-1:0] s_prev_q;

  // Control inputs must be known on every active edge out of reset.
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!$isunknown({clear_i, load_i, en_i, down_i}))
        else $error("counter: X/Z on control input");
    end
  end

  // Remember whether the previous edge was idle and what the count was then.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_prev_idle <= 1'b0;
      s_prev_q    <= '0;
    end else begin
      s_prev_idle <= ~(clear_i | load_i | en_i);
      s_prev_q    <= q_o;
    end
  end

  // An idle edge must leave the count untouched.
  always @(posedge clk_i) begin
    if (rst_ni && s_prev_idle) begin
      assert (q_o == s_prev_q)
        else $error("counter: q_o changed after an idle edge");
    end
  end
`else
  // Checks disabled: no simulation-only logic in this build.
`endif

endmodule

// File: tb/tb_counter.sv
// tb_counter: directed-vector bench for counter. Three instances share the
// controls: A (WIDTH=4, pulse), B (WIDTH=4, sticky), C (WIDTH=1, pulse).
module tb_counter;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       en;
  logic       load;
  logic       down;
  logic [3:0] d4;
  logic       d1;

  logic [3:0] q_a;
  logic       ovf_a;
  logic [3:0] q_b;
  logic       ovf_b;
  logic       q_c;
  logic       ovf_c;

  int errors = 0;
  int checks = 0;

  counter #(.WIDTH(4), .STICKY_OVERFLOW(1'b0)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .en_i(en), .load_i(load),
    .down_i(down), .d_i(d4), .q_o(q_a), .overflow_o(ovf_a)
  );

  counter #(.WIDTH(4), .STICKY_OVERFLOW(1'b1)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .en_i(en), .load_i(load),
    .down_i(down), .d_i(d4), .q_o(q_b), .overflow_o(ovf_b)
  );

  counter #(.WIDTH(1), .STICKY_OVERFLOW(1'b0)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .en_i(en), .load_i(load),
    .down_i(down), .d_i(d1), .q_o(q_c), .overflow_o(ovf_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input logic c, input logic l, input logic e, input logic dn,
                         input logic [3:0] dv4, input logic dv1);
    clear = c; load = l; en = e; down = dn; d4 = dv4; d1 = dv1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_ctl(0, 0, 0, 0, 4'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_q_a", q_a, 0);
    check("rst_ovf_a", ovf_a, 0);
    check("rst_q_b", q_b, 0);
    check("rst_q_c", q_c, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Count up 17 steps: 1..15, 0, 1.
    set_ctl(0, 0, 1, 0, 4'd0, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      step();
      check($sformatf("up%0d_q_a", i), q_a, i % 16);
      check($sformatf("up%0d_ovf_a", i), ovf_a, (i == 16) ? 1 : 0);
      check($sformatf("up%0d_ovf_b", i), ovf_b, (i >= 16) ? 1 : 0);
      check($sformatf("up%0d_q_c", i), q_c, i % 2);
      check($sformatf("up%0d_ovf_c", i), ovf_c, (i % 2 == 0) ? 1 : 0);
    end

    // Load 0; load clears the sticky flag.
    set_ctl(0, 1, 0, 0, 4'd0, 1'b0);
    step();
    check("ld0_q_b", q_b, 0);
    check("ld0_ovf_b", ovf_b, 0);
    check("ld0_q_c", q_c, 0);

    // Count down 3 steps: 15, 14, 13.
    set_ctl(0, 0, 1, 1, 4'd0, 1'b0);
    step();
    check("dn1_q_b", q_b, 15);
    check("dn1_ovf_b", ovf_b, 1);
    check("dn1_ovf_a", ovf_a, 1);
    check("dn1_q_c", q_c, 1);
    check("dn1_ovf_c", ovf_c, 1);
    step();
    check("dn2_q_b", q_b, 14);
    check("dn2_ovf_b", ovf_b, 1);
    check("dn2_ovf_a", ovf_a, 0);
    check("dn2_q_c", q_c, 0);
    check("dn2_ovf_c", ovf_c, 0);
    step();
    check("dn3_q_b", q_b, 13);
    check("dn3_ovf_b", ovf_b, 1);
    check("dn3_q_c", q_c, 1);
    check("dn3_ovf_c", ovf_c, 1);

    // Load 5 clears the sticky flag.
    set_ctl(0, 1, 0, 0, 4'd5, 1'b1);
    step();
    check("ld5_q_b", q_b, 5);
    check("ld5_ovf_b", ovf_b, 0);
    check("ld5_q_a", q_a, 5);

    // Sticky survives further counting, then clear drops it.
    set_ctl(0, 1, 0, 0, 4'd15, 1'b0);
    step();
    check("ld15_q_a", q_a, 15);
    set_ctl(0, 0, 1, 0, 4'd0, 1'b0);
    step();
    check("wrap_q_a", q_a, 0);
    check("wrap_ovf_a", ovf_a, 1);
    check("wrap_ovf_b", ovf_b, 1);
    step();
    check("post_q_b", q_b, 1);
    check("post_ovf_a", ovf_a, 0);
    check("post_ovf_b", ovf_b, 1);
    set_ctl(1, 0, 0, 0, 4'd0, 1'b0);
    step();
    check("clr_q_b", q_b, 0);
    check("clr_ovf_b", ovf_b, 0);

    // Priority: clear beats load and enable; load beats enable.
    set_ctl(0, 1, 0, 0, 4'd7, 1'b0);
    step();
    check("ld7_q_a", q_a, 7);
    set_ctl(1, 1, 1, 0, 4'd9, 1'b1);
    step();
    check("pri_clr_q_a", q_a, 0);
    check("pri_clr_ovf_a", ovf_a, 0);
    set_ctl(0, 1, 1, 0, 4'd9, 1'b1);
    step();
    check("pri_ld_q_a", q_a, 9);
    check("pri_ld_q_b", q_b, 9);

    // Hold at 6 with down/d toggling.
    set_ctl(0, 1, 0, 0, 4'd6, 1'b0);
    step();
    check("ld6_q_a", q_a, 6);
    for (int i = 0; i < 5; i++) begin
      set_ctl(0, 0, 0, i[0], 4'(i * 3 + 1), ~i[0]);
      step();
      check($sformatf("hold%0d_q_a", i), q_a, 6);
      check($sformatf("hold%0d_ovf_a", i), ovf_a, 0);
      check($sformatf("hold%0d_q_b", i), q_b, 6);
    end

    // Asynchronous reset mid-count at 11.
    set_ctl(0, 1, 0, 0, 4'd11, 1'b0);
    step();
    check("ld11_q_a", q_a, 11);
    set_ctl(0, 0, 1, 0, 4'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_q_a", q_a, 0);
    check("arst_q_b", q_b, 0);
    step();
    check("arst_hold_q_a", q_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rel_q_a", q_a, 1);
    check("rel_ovf_a", ovf_a, 0);
    check("rel_q_b", q_b, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
